// File: rtl/ppi_bus_controller.sv
// rtl/ppi_bus_controller.sv - PPI bus controller: strobe synchronisers, address decode and write commit
module ppi_bus_controller #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] CTRL_RESET = DATA_W'(8'h9B),
  localparam int NUM_PORTS  = (1 << ADDR_W) - 1
) (
  input  logic                 CLK,
  input  logic                 RESET_bar,
  input  logic                 CS_bar,
  input  logic                 RD_bar,
  input  logic                 WR_bar,
  input  logic [ADDR_W-1:0]    A,
  input  logic [DATA_W-1:0]    D_IN,
  output logic [NUM_PORTS-1:0] port_wr_stb,
  output logic [DATA_W-1:0]    wr_data,
  output logic [ADDR_W-1:0]    port_rd_sel,
  output logic                 data_oe,
  output logic [DATA_W-1:0]    ctrl_word,
  output logic                 mode_set_stb,
  output logic                 port_clr,
  output logic                 bsr_stb,
  output logic [2:0]           bsr_bit,
  output logic                 bsr_val,
  output logic                 bus_err
);

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT} state_t;

  localparam logic [ADDR_W-1:0] CTRL_ADDR = '1;

  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic                   cs, rd, wr;

  state_t                 state_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      data_q;
  logic [NUM_PORTS-1:0]   port_wr_stb_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic [ADDR_W-1:0]      port_rd_sel_q;
  logic                   data_oe_q;
  logic [DATA_W-1:0]      ctrl_word_q;
  logic                   mode_set_stb_q;
  logic                   port_clr_q;
  logic                   bsr_stb_q;
  logic [2:0]             bsr_bit_q;
  logic                   bsr_val_q;
  logic                   bus_err_q;

  // Synchronisers idle high so releasing reset never looks like a strobe edge.
  always_ff @(posedge CLK or negedge RESET_bar) begin
    if (!RESET_bar) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], CS_bar};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], RD_bar};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], WR_bar};
    end
  end

  assign cs = ~cs_sync_q[SYNC_STAGES-1];
  assign rd = ~rd_sync_q[SYNC_STAGES-1];
  assign wr = ~wr_sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RESET_bar) begin
    if (!RESET_bar) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      port_wr_stb_q  <= '0;
      wr_data_q      <= '0;
      port_rd_sel_q  <= '0;
      data_oe_q      <= 1'b0;
      ctrl_word_q    <= CTRL_RESET;
      mode_set_stb_q <= 1'b0;
      port_clr_q     <= 1'b0;
      bsr_stb_q      <= 1'b0;
      bsr_bit_q      <= 3'd0;
      bsr_val_q      <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      port_wr_stb_q  <= '0;
      mode_set_stb_q <= 1'b0;
      port_clr_q     <= 1'b0;
      bsr_stb_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cs && rd && wr) begin
            bus_err_q <= 1'b1;
          end else if (cs && wr) begin
            state_q <= WR_ACT;
            addr_q  <= A;
            data_q  <= D_IN;
          end else if (cs && rd) begin
            state_q       <= RD_ACT;
            port_rd_sel_q <= A;
          end
        end

        WR_ACT: begin
          if (rd) begin
            bus_err_q <= 1'b1;
            state_q   <= IDLE;
          end else if (!wr) begin
            // Strobe end seen: commit the last sample taken while the strobe was low.
            state_q   <= IDLE;
            wr_data_q <= data_q;
            if (addr_q != CTRL_ADDR) begin
              port_wr_stb_q <= NUM_PORTS'(1) << addr_q;
            end else if (data_q[DATA_W-1]) begin
              ctrl_word_q    <= data_q;
              mode_set_stb_q <= 1'b1;
              port_clr_q     <= 1'b1;
            end else begin
              bsr_stb_q <= 1'b1;
              bsr_bit_q <= data_q[3:1];
              bsr_val_q <= data_q[0];
            end
          end else if (!cs) begin
            state_q <= IDLE;
          end else begin
            addr_q <= A;
            data_q <= D_IN;
          end
        end

        RD_ACT: begin
          if (wr) begin
            bus_err_q <= 1'b1;
            data_oe_q <= 1'b0;
            state_q   <= IDLE;
          end else if (!rd || !cs) begin
            data_oe_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            data_oe_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_wr_stb  = port_wr_stb_q;
  assign wr_data      = wr_data_q;
  assign port_rd_sel  = port_rd_sel_q;
  assign data_oe      = data_oe_q;
  assign ctrl_word    = ctrl_word_q;
  assign mode_set_stb = mode_set_stb_q;
  assign port_clr     = port_clr_q;
  assign bsr_stb      = bsr_stb_q;
  assign bsr_bit      = bsr_bit_q;
  assign bsr_val      = bsr_val_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_ppi_bus_controller.sv
// tb/tb_ppi_bus_controller.sv - self-checking bench for ppi_bus_controller
module tb_ppi_bus_controller;
  localparam int SYNC = 2;

  logic       CLK = 1'b0;
  logic       RESET_bar, CS_bar, RD_bar, WR_bar;
  logic [1:0] A;
  logic [7:0] D_IN;
  logic [2:0] port_wr_stb;
  logic [7:0] wr_data, ctrl_word;
  logic [1:0] port_rd_sel;
  logic       data_oe, mode_set_stb, port_clr, bsr_stb, bsr_val, bus_err;
  logic [2:0] bsr_bit;

  ppi_bus_controller #(.DATA_W(8), .ADDR_W(2), .SYNC_STAGES(SYNC), .CTRL_RESET(8'h9B)) dut (
    .CLK(CLK), .RESET_bar(RESET_bar), .CS_bar(CS_bar), .RD_bar(RD_bar), .WR_bar(WR_bar),
    .A(A), .D_IN(D_IN), .port_wr_stb(port_wr_stb), .wr_data(wr_data),
    .port_rd_sel(port_rd_sel), .data_oe(data_oe), .ctrl_word(ctrl_word),
    .mode_set_stb(mode_set_stb), .port_clr(port_clr), .bsr_stb(bsr_stb),
    .bsr_bit(bsr_bit), .bsr_val(bsr_val), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    int         len;
    logic [2:0] stb;
    logic       mode;
    logic       bsr;
    logic [2:0] bbit;
    logic       val;
    logic [7:0] ctrl;
  } vec_t;

  vec_t vecs[8];
  vec_t exp_q[$];
  vec_t mon_e;
  vec_t extra;
  int   checks = 0, failures = 0;
  int   cyc = 0, last_rise = 0, strobe_cnt = 0;
  int   n_before, lat, rd_rise;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if ((|port_wr_stb) || mode_set_stb || port_clr || bsr_stb) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_queue_size", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("port_wr_stb", port_wr_stb, mon_e.stb);
        chk("mode_set_stb", mode_set_stb, mon_e.mode);
        chk("port_clr", port_clr, mon_e.mode);
        chk("bsr_stb", bsr_stb, mon_e.bsr);
        chk("wr_data", wr_data, mon_e.d);
        chk("ctrl_word", ctrl_word, mon_e.ctrl);
        if (mon_e.bsr) begin
          chk("bsr_bit", bsr_bit, mon_e.bbit);
          chk("bsr_val", bsr_val, mon_e.val);
        end
        chk($sformatf("write_latency_in_range lat=%0d", cyc - last_rise),
            (cyc - last_rise >= SYNC + 1) && (cyc - last_rise <= SYNC + 2), 1);
      end
    end
  end

  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int len);
    @(posedge CLK); #2;
    A = a; D_IN = d; CS_bar = 1'b0; WR_bar = 1'b0;
    repeat (len) @(posedge CLK);
    #2; WR_bar = 1'b1; last_rise = cyc;
    @(posedge CLK); #2; CS_bar = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
    chk("write_drained", exp_q.size(), 0);
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd1, 8'h5A, 4, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0, 8'h9B};
    vecs[1] = '{2'd0, 8'hA5, 2, 3'b001, 1'b0, 1'b0, 3'd0, 1'b0, 8'h9B};
    vecs[2] = '{2'd2, 8'hFF, 1, 3'b100, 1'b0, 1'b0, 3'd0, 1'b0, 8'h9B};
    vecs[3] = '{2'd3, 8'h80, 3, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h80};
    vecs[4] = '{2'd3, 8'h07, 2, 3'b000, 1'b0, 1'b1, 3'd3, 1'b1, 8'h80};
    vecs[5] = '{2'd3, 8'h0C, 3, 3'b000, 1'b0, 1'b1, 3'd6, 1'b0, 8'h80};
    vecs[6] = '{2'd3, 8'hC1, 2, 3'b000, 1'b1, 1'b0, 3'd0, 1'b0, 8'hC1};
    vecs[7] = '{2'd1, 8'h00, 5, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0, 8'hC1};

    RESET_bar = 1'b0; CS_bar = 1'b1; RD_bar = 1'b1; WR_bar = 1'b1; A = 2'd0; D_IN = 8'h00;
    repeat (3) @(posedge CLK);
    #2;
    chk("reset_ctrl_word", ctrl_word, 8'h9B);
    chk("reset_wr_data", wr_data, 8'h00);
    chk("reset_port_rd_sel", port_rd_sel, 2'd0);
    chk("reset_data_oe_bus_err", {data_oe, bus_err}, 2'b00);
    @(posedge CLK); #2; RESET_bar = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("idle_outputs", {ctrl_word, data_oe, port_wr_stb, mode_set_stb, port_clr, bsr_stb, bus_err},
          {8'h9B, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    end

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i]);
      do_write(vecs[i].a, vecs[i].d, vecs[i].len);
    end
    chk("ctrl_word_after_table", ctrl_word, 8'hC1);
    chk("strobe_count_after_table", strobe_cnt, 8);

    // CS_bar released while WR_bar still low: write must be dropped.
    n_before = strobe_cnt;
    @(posedge CLK); #2;
    A = 2'd0; D_IN = 8'h33; CS_bar = 1'b0; WR_bar = 1'b0;
    repeat (3) @(posedge CLK);
    #2; CS_bar = 1'b1;
    repeat (2) @(posedge CLK);
    #2; WR_bar = 1'b1;
    repeat (10) @(posedge CLK);
    chk("abort_no_strobe", strobe_cnt, n_before);

    // Read of the control register.
    @(posedge CLK); #2;
    A = 2'd3; CS_bar = 1'b0; RD_bar = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("read_port_rd_sel", port_rd_sel, 2'd3);
    chk("read_data_oe_high", data_oe, 1'b1);
    @(posedge CLK); #2; RD_bar = 1'b1; rd_rise = cyc;
    for (int i = 0; i < 10 && data_oe !== 1'b0; i++) @(negedge CLK);
    lat = cyc - rd_rise;
    chk($sformatf("read_oe_drop lat=%0d", lat), (data_oe === 1'b0) && (lat <= SYNC + 1), 1);
    @(posedge CLK); #2; CS_bar = 1'b1;
    repeat (3) @(posedge CLK);

    // Read of port 1.
    @(posedge CLK); #2;
    A = 2'd1; CS_bar = 1'b0; RD_bar = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("read1_port_rd_sel", port_rd_sel, 2'd1);
    chk("read1_data_oe_high", data_oe, 1'b1);
    @(posedge CLK); #2; RD_bar = 1'b1; CS_bar = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("read1_data_oe_low", data_oe, 1'b0);

    // RD and WR low together.
    chk("bus_err_before", bus_err, 1'b0);
    n_before = strobe_cnt;
    @(posedge CLK); #2;
    CS_bar = 1'b0; RD_bar = 1'b0; WR_bar = 1'b0;
    repeat (3) @(posedge CLK);
    #2; RD_bar = 1'b1; WR_bar = 1'b1; CS_bar = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("bus_err_set", bus_err, 1'b1);
    chk("bus_err_no_strobe", strobe_cnt, n_before);
    chk("bus_err_data_oe", data_oe, 1'b0);
    extra = '{2'd0, 8'h3C, 3, 3'b001, 1'b0, 1'b0, 3'd0, 1'b0, 8'hC1};
    exp_q.push_back(extra);
    do_write(extra.a, extra.d, extra.len);
    chk("bus_err_sticky", bus_err, 1'b1);

    // Reset during WR_ACT.
    @(posedge CLK); #2;
    A = 2'd0; D_IN = 8'h11; CS_bar = 1'b0; WR_bar = 1'b0;
    repeat (4) @(posedge CLK);
    #2; RESET_bar = 1'b0;
    #1;
    chk("midreset_ctrl_word", ctrl_word, 8'h9B);
    chk("midreset_bus_err", bus_err, 1'b0);
    chk("midreset_wr_data", wr_data, 8'h00);
    chk("midreset_oe_stb", {data_oe, port_wr_stb}, 4'b0000);
    n_before = strobe_cnt;
    @(posedge CLK); #2; WR_bar = 1'b1; CS_bar = 1'b1;
    repeat (2) @(posedge CLK);
    #2; RESET_bar = 1'b1;
    repeat (10) @(posedge CLK);
    chk("midreset_no_strobe", strobe_cnt, n_before);

    extra = '{2'd2, 8'hE7, 2, 3'b100, 1'b0, 1'b0, 3'd0, 1'b0, 8'h9B};
    exp_q.push_back(extra);
    do_write(extra.a, extra.d, extra.len);
    chk("post_reset_bus_err", bus_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
